// File: rtl/monishvr_fifo.sv
// monishvr_fifo: single-clock 8x4 FIFO in a TinyTapeout user-tile wrapper.
// Define FIFO_STICKY_FLAGS_EN to build the sticky overflow/underflow flags on uo_out[7:6].
module monishvr_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam int AW = $clog2(DEPTH);

   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic [3:0]    wr_data;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    rd_data;
   logic [3:0]    mem [DEPTH];

   logic          empty;
   logic          full;
   logic          wr_do;
   logic          rd_do;
   logic [1:0]    sticky;
   logic [7:0]    count_ext;
   logic          unused_ok;

   assign flush   = ui_in[0];
   assign wr_en   = ui_in[2];
   assign rd_en   = ui_in[3];
   assign wr_data = ui_in[7:4];

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // When full, a simultaneous read frees the slot the write lands in.
   assign rd_do = rd_en && !empty && !flush;
   assign wr_do = wr_en && (!full || rd_en) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= 4'h0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_do)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_do) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= mem[rd_ptr];
         end
         count <= count + (AW+1)'(wr_do) - (AW+1)'(rd_do);
      end
   end

   // Storage is not reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_do)
         mem[wr_ptr] <= wr_data;
   end

`ifdef FIFO_STICKY_FLAGS_EN
   logic overflow;
   logic underflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full && !rd_en)
            overflow <= 1'b1;
         if (rd_en && empty && !wr_en)
            underflow <= 1'b1;
      end
   end

   assign sticky = {underflow, overflow};
`else
   assign sticky = 2'b00;
`endif

   assign count_ext = 8'(count);

   assign uo_out  = {sticky, full, empty, rd_data};
   assign uio_out = {4'h0, count_ext[3:0]};
   assign uio_oe  = 8'h0F;

   assign unused_ok = &{1'b0, ena, uio_in, ui_in[1], count_ext[7:4]};

endmodule

// File: tb/tb_monishvr_fifo.sv
// tb_monishvr_fifo: directed and randomized checks of monishvr_fifo against a queue model.
module tb_monishvr_fifo;
   localparam int DEPTH = 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk;
   int n_pass;

   logic [3:0] q [$];
   logic [3:0] m_rd;
   logic       m_ovf;
   logic       m_udf;

   monishvr_fifo dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_rd  = 4'h0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   function automatic logic [7:0] exp_uo();
      logic [1:0] fl;
`ifdef FIFO_STICKY_FLAGS_EN
      fl = {m_udf, m_ovf};
`else
      fl = 2'b00;
`endif
      return {fl, q.size() == DEPTH, q.size() == 0, m_rd};
   endfunction

   task automatic check_all(input string tag);
      chk(tag, uo_out, exp_uo());
      chk({tag, "_cnt"}, uio_out, 8'(q.size()));
   endtask

   // One clock: drive at negedge, apply FIFO rules to the model at posedge, compare after.
   task automatic step(input string tag, input bit fl, input bit wr, input bit rd, input logic [3:0] d);
      bit was_full;
      bit was_empty;
      @(negedge clk);
      ui_in = {d, rd, wr, 1'b0, fl};
      @(posedge clk);
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (wr && was_full && !rd) m_ovf = 1'b1;
         if (rd && was_empty && !wr) m_udf = 1'b1;
         if (rd && !was_empty) m_rd = q.pop_front();
         if (wr && (!was_full || rd)) q.push_back(d);
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      ena    = 1'b1;
      uio_in = 8'h00;
      rst_n  = 1'b0;
      ui_in  = {4'hA, 1'b1, 1'b1, 2'b00};
      model_reset();

      // Strobes held during reset must be ignored.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_uo", uo_out, 8'h10);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'h0F);

      @(negedge clk);
      rst_n = 1'b1;
      ui_in = 8'h00;

      step("wr_a", 0, 1, 0, 4'hA);
      chk("wr_a_count", uio_out, 8'h01);
      step("rd_a", 0, 0, 1, 4'h0);
      chk("rd_a_data", {4'h0, uo_out[3:0]}, 8'h0A);
      step("wr_c", 0, 1, 0, 4'hC);
      step("rd_c", 0, 0, 1, 4'h0);

      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 1; i <= 8; i++) step("fill", 0, 1, 0, 4'(i));
         chk("fill_full", {7'h0, uo_out[5]}, 8'h01);
         step("over", 0, 1, 0, 4'hF);
         for (int i = 1; i <= 8; i++) begin
            step("drain", 0, 0, 1, 4'h0);
            chk("drain_val", {4'h0, uo_out[3:0]}, 8'(i));
         end
      end

      step("under", 0, 0, 1, 4'h0);
      step("under_hold", 0, 0, 0, 4'h0);
      step("flush0", 1, 0, 0, 4'h0);

      step("rw_empty", 0, 1, 1, 4'h5);
      for (int i = 0; i < 7; i++) step("fill2", 0, 1, 0, 4'(8 + i));
      step("rw_full", 0, 1, 1, 4'h3);
      step("rw_full2", 0, 1, 1, 4'h4);

      step("flush1", 1, 0, 0, 4'h0);
      for (int i = 0; i < 3; i++) step("pre_fl", 0, 1, 0, 4'(i + 2));
      step("flush_rw", 1, 1, 1, 4'h7);

      for (int i = 0; i < 400; i++) begin
         bit wr;
         bit rd;
         wr = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         rd = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
         step("rand", $urandom_range(0, 31) == 0, wr, rd, 4'($urandom));
      end

      for (int i = 0; i < 5; i++) step("pre_rst", 0, 1, 0, 4'(i + 9));
      // Reset asserted between edges while a write is being presented.
      @(posedge clk);
      #3;
      ui_in = {4'h9, 1'b0, 1'b1, 2'b00};
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_uo", uo_out, 8'h10);
      chk("async_uio", uio_out, 8'h00);
      @(posedge clk);
      #1;
      chk("async_hold", uo_out, 8'h10);
      @(negedge clk);
      rst_n = 1'b1;
      ui_in = 8'h00;

      for (int i = 0; i < 150; i++)
         step("rand2", $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 4'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
